// File: rtl/fft_pkg.sv
// Shared constants and arithmetic helpers for the streaming FFT datapath.
//   DATA_W_DEF / TW_W_DEF : default sample and twiddle component widths
//   TW_ONE                : largest positive Q1.(TW_W_DEF-1) twiddle value
//   rnd_const()           : round-half-up offset applied before the Q1.x shift
//   sat() / is_sat()      : clamp a signed value to a given width / test for clipping
package fft_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned TW_W_DEF   = 16;
  localparam int          TW_ONE     = (1 << (TW_W_DEF - 1)) - 1;

  // Half an LSB of the product after dropping TW_W-1 fractional bits.
  function automatic logic signed [63:0] rnd_const(input int unsigned tw_w);
    return 64'sd1 <<< (tw_w - 2);
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] x,
                                              input int unsigned        width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

  function automatic logic is_sat(input logic signed [63:0] x,
                                  input int unsigned        width);
    return sat(x, width) != x;
  endfunction

endpackage

// File: rtl/fft_cmul_pipe.sv
// Two-stage pipelined complex multiply t = b * w (or b * conj(w)) with
// round-half-up back to sample scale. Stages advance together on adv.
//   clk, rst_n        : clock, async active-low reset
//   adv               : stage enable; when low every register holds
//   in_valid          : b/w/inverse valid this cycle
//   b_re, b_im        : DATA_W signed multiplicand
//   w_re, w_im        : TW_W signed Q1.(TW_W-1) twiddle
//   inverse           : use conj(w)
//   out_valid         : t_re/t_im valid
//   t_re, t_im        : DATA_W+2 signed rounded product (not saturated)
module fft_cmul_pipe
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned TW_W   = TW_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     adv,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic signed [TW_W-1:0]   w_re,
  input  logic signed [TW_W-1:0]   w_im,
  input  logic                     inverse,
  output logic                     out_valid,
  output logic signed [DATA_W+1:0] t_re,
  output logic signed [DATA_W+1:0] t_im
);

  localparam int unsigned PW = DATA_W + TW_W;
  localparam int unsigned SW = PW + 1;

  localparam logic signed [TW_W-1:0] W_MIN = {1'b1, {(TW_W-1){1'b0}}};
  localparam logic signed [TW_W-1:0] W_MAX = {1'b0, {(TW_W-1){1'b1}}};
  localparam logic signed [SW-1:0]   RND   = SW'(rnd_const(TW_W));

  logic signed [TW_W-1:0] wi_eff;
  logic                   v1;
  logic signed [PW-1:0]   p0, p1, p2, p3;
  logic signed [SW-1:0]   tr, ti;

  // Conjugation must not wrap the most negative twiddle back onto itself.
  always_comb begin
    wi_eff = w_im;
    if (inverse) wi_eff = (w_im == W_MIN) ? W_MAX : -w_im;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      p0 <= '0;
      p1 <= '0;
      p2 <= '0;
      p3 <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        p0 <= PW'(b_re) * PW'(w_re);
        p1 <= PW'(b_im) * PW'(wi_eff);
        p2 <= PW'(b_re) * PW'(wi_eff);
        p3 <= PW'(b_im) * PW'(w_re);
      end
    end
  end

  always_comb begin
    tr = SW'(p0) - SW'(p1) + RND;
    ti = SW'(p2) + SW'(p3) + RND;
  end

  // Dropping the low TW_W-1 bits of an SW-bit word leaves exactly DATA_W+2
  // bits, so the arithmetic shift and the width truncation are one slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      t_re      <= '0;
      t_im      <= '0;
    end else if (adv) begin
      out_valid <= v1;
      t_re      <= tr[SW-1:TW_W-1];
      t_im      <= ti[SW-1:TW_W-1];
    end
  end

endmodule

// File: rtl/fft_bfly_r2_pipe.sv
// Three-stage pipelined radix-2 DIT butterfly: A = a + w*b, B = a - w*b,
// with optional divide-by-2, conjugate-twiddle mode, output saturation and a
// sticky overflow flag. Valid/ready handshake; the whole pipe stalls together.
//   clk, rst_n                 : clock, async active-low reset
//   in_valid / in_ready        : input handshake (in_ready = !out_valid | out_ready)
//   a_*, b_*                   : DATA_W signed butterfly inputs
//   w_re, w_im                 : TW_W signed Q1.(TW_W-1) twiddle
//   scale, inverse             : per-word controls captured with the input
//   out_valid / out_ready      : output handshake
//   A_*, B_*                   : DATA_W signed saturated outputs
//   ovf / clr_ovf              : sticky saturation flag and its synchronous clear
module fft_bfly_r2_pipe
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned TW_W   = TW_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic signed [TW_W-1:0]   w_re,
  input  logic signed [TW_W-1:0]   w_im,
  input  logic                     scale,
  input  logic                     inverse,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] A_re,
  output logic signed [DATA_W-1:0] A_im,
  output logic signed [DATA_W-1:0] B_re,
  output logic signed [DATA_W-1:0] B_im,
  output logic                     ovf,
  input  logic                     clr_ovf
);

  localparam int unsigned TW = DATA_W + 2;
  localparam logic signed [TW-1:0] ONE = TW'(1);

  logic                     adv;
  logic                     v2;
  logic signed [TW-1:0]     t_re, t_im;
  logic signed [DATA_W-1:0] a1_re, a1_im, a2_re, a2_im;
  logic                     sc1, sc2;
  logic signed [TW-1:0]     s [4];
  logic signed [TW-1:0]     ss [4];
  logic signed [DATA_W-1:0] y [4];
  logic [3:0]               hit;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  fft_cmul_pipe #(
    .DATA_W (DATA_W),
    .TW_W   (TW_W)
  ) u_cmul (
    .clk       (clk),
    .rst_n     (rst_n),
    .adv       (adv),
    .in_valid  (in_valid),
    .b_re      (b_re),
    .b_im      (b_im),
    .w_re      (w_re),
    .w_im      (w_im),
    .inverse   (inverse),
    .out_valid (v2),
    .t_re      (t_re),
    .t_im      (t_im)
  );

  // a and scale ride alongside the multiplier's two stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_re <= '0;
      a1_im <= '0;
      sc1   <= 1'b0;
      a2_re <= '0;
      a2_im <= '0;
      sc2   <= 1'b0;
    end else if (adv) begin
      if (in_valid) begin
        a1_re <= a_re;
        a1_im <= a_im;
        sc1   <= scale;
      end
      a2_re <= a1_re;
      a2_im <= a1_im;
      sc2   <= sc1;
    end
  end

  always_comb begin
    s[0] = TW'(a2_re) + t_re;
    s[1] = TW'(a2_im) + t_im;
    s[2] = TW'(a2_re) - t_re;
    s[3] = TW'(a2_im) - t_im;
    hit  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      ss[i]  = sc2 ? ((s[i] + ONE) >>> 1) : s[i];
      y[i]   = DATA_W'(sat(64'(ss[i]), DATA_W));
      hit[i] = is_sat(64'(ss[i]), DATA_W);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      A_re      <= '0;
      A_im      <= '0;
      B_re      <= '0;
      B_im      <= '0;
      ovf       <= 1'b0;
    end else begin
      if (adv) begin
        out_valid <= v2;
        if (v2) begin
          A_re <= y[0];
          A_im <= y[1];
          B_re <= y[2];
          B_im <= y[3];
        end
      end
      // A fresh saturation takes priority over a coincident clear.
      if (adv && v2 && (|hit)) ovf <= 1'b1;
      else if (clr_ovf)        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_bfly_r2_pipe.sv
module tb_fft_bfly_r2_pipe;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic signed [15:0] w_re = '0, w_im = '0;
  logic               scale = 1'b0, inverse = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] A_re, A_im, B_re, B_im;
  logic               ovf;
  logic               clr_ovf = 1'b0;

  fft_bfly_r2_pipe #(.DATA_W(16), .TW_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_re      (a_re),
    .a_im      (a_im),
    .b_re      (b_re),
    .b_im      (b_im),
    .w_re      (w_re),
    .w_im      (w_im),
    .scale     (scale),
    .inverse   (inverse),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A_re      (A_re),
    .A_im      (A_im),
    .B_re      (B_re),
    .B_im      (B_im),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ar, ai, br, bi, wr, wi;
    bit sc, inv;
    int xar, xai, xbr, xbi;
    bit xovf;
  } vec_t;

  typedef struct {
    longint ar, ai, br, bi;
    bit     ovf;
  } res_t;

  int   checks   = 0;
  int   failures = 0;
  res_t exp_q[$];
  vec_t tbl[6];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint rnd_half_up(input longint num, input real den);
    return longint'($floor(real'(num) / den + 0.5));
  endfunction

  // Butterfly from its arithmetic definition: exact products, round to
  // nearest (ties up) to sample scale, optional halving, then clamp.
  function automatic res_t model(input int ar, input int ai, input int br, input int bi,
                                 input int wr, input int wi, input bit sc, input bit inv);
    longint wie, tr, ti, t_re, t_im;
    longint s [4];
    res_t   r;
    wie  = inv ? ((wi == -32768) ? 32767 : -longint'(wi)) : longint'(wi);
    tr   = longint'(br) * wr - longint'(bi) * wie;
    ti   = longint'(br) * wie + longint'(bi) * wr;
    t_re = rnd_half_up(tr, 32768.0);
    t_im = rnd_half_up(ti, 32768.0);
    s[0] = ar + t_re;
    s[1] = ai + t_im;
    s[2] = ar - t_re;
    s[3] = ai - t_im;
    r.ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (sc) s[i] = rnd_half_up(s[i], 2.0);
      if (s[i] > 32767)       begin s[i] = 32767;  r.ovf = 1'b1; end
      else if (s[i] < -32768) begin s[i] = -32768; r.ovf = 1'b1; end
    end
    r.ar = s[0]; r.ai = s[1]; r.br = s[2]; r.bi = s[3];
    return r;
  endfunction

  function automatic int rs16();
    logic signed [15:0] t;
    t = 16'($urandom);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    a_re = 16'(v.ar); a_im = 16'(v.ai);
    b_re = 16'(v.br); b_im = 16'(v.bi);
    w_re = 16'(v.wr); w_im = 16'(v.wi);
    scale = v.sc; inverse = v.inv;
  endtask

  task automatic clear_ovf();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
  endtask

  // Present one word for one cycle and count edges until out_valid rises.
  task automatic send_one_wait(input vec_t v, output int lat);
    drive(v);
    in_valid = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      in_valid = 1'b0;
    end while (!out_valid && lat < 20);
  endtask

  task automatic stream(input int n, input int hold_lo, input int hold_hi,
                        input int rdy_pct, input int vld_pct);
    int   sent = 0, got = 0, cyc = 0;
    bit   sticky = 1'b0;
    res_t e;
    vec_t v;
    clear_ovf();
    while ((sent < n || exp_q.size() != 0) && cyc < 3000) begin
      out_ready = (cyc >= hold_lo && cyc < hold_hi) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      if (sent < n && $urandom_range(99) < vld_pct) begin
        v.ar = rs16(); v.ai = rs16(); v.br = rs16(); v.bi = rs16();
        v.wr = rs16(); v.wi = rs16();
        v.sc = 1'($urandom); v.inv = 1'($urandom);
        drive(v);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= hold_lo && cyc < hold_hi && out_valid) chk("bp_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_output_queue", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          sticky |= e.ovf;
          chk($sformatf("s%0d_A_re", got), A_re, e.ar);
          chk($sformatf("s%0d_A_im", got), A_im, e.ai);
          chk($sformatf("s%0d_B_re", got), B_re, e.br);
          chk($sformatf("s%0d_B_im", got), B_im, e.bi);
          chk($sformatf("s%0d_ovf", got), ovf, sticky);
          got++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(v.ar, v.ai, v.br, v.bi, v.wr, v.wi, v.sc, v.inv));
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", got, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   stale;
    vec_t v;

    tbl[0] = '{1000, 0, 200, 0, 32767, 0,      0, 0, 1200, 0,    800,  0,    0};
    tbl[1] = '{1000, 0, 200, 0, 32767, 0,      1, 0, 600,  0,    400,  0,    0};
    tbl[2] = '{1000, 0, 200, 0, 0,     -32768, 0, 0, 1000, -200, 1000, 200,  0};
    tbl[3] = '{1000, 0, 200, 0, 0,     -32768, 0, 1, 1000, 200,  1000, -200, 0};
    tbl[4] = '{32767, 0, 32767, 0, 32767, 0,   0, 0, 32767, 0,   1,    0,    1};
    tbl[5] = '{32767, 0, 32767, 0, 32767, 0,   1, 0, 32767, 0,   1,    0,    0};

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_A_re", A_re, 0);
    chk("rst_B_im", B_im, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      clear_ovf();
      send_one_wait(tbl[i], lat);
      chk($sformatf("v%0d_latency", i), lat, 3);
      chk($sformatf("v%0d_A_re", i), A_re, tbl[i].xar);
      chk($sformatf("v%0d_A_im", i), A_im, tbl[i].xai);
      chk($sformatf("v%0d_B_re", i), B_re, tbl[i].xbr);
      chk($sformatf("v%0d_B_im", i), B_im, tbl[i].xbi);
      chk($sformatf("v%0d_ovf", i), ovf, tbl[i].xovf);
      tick();
    end

    // ovf is sticky across clean words until cleared
    clear_ovf();
    send_one_wait(tbl[4], lat);
    repeat (4) tick();
    chk("sticky_hold", ovf, 1);
    send_one_wait(tbl[0], lat);
    chk("sticky_after_clean", ovf, 1);
    clear_ovf();
    chk("sticky_cleared", ovf, 0);

    // Clear held high while a saturating word lands: set wins, then clears
    clr_ovf = 1'b1;
    send_one_wait(tbl[4], lat);
    chk("set_wins_ovf", ovf, 1);
    tick();
    chk("clear_after_set", ovf, 0);
    clr_ovf = 1'b0;
    tick();

    // Backpressure burst of 8 with a 5-cycle output stall
    stream(8, 4, 9, 100, 100);
    // Randomized traffic with random stalls and bubbles
    stream(150, -1, -1, 60, 70);

    // Reset with three words in flight
    clear_ovf();
    for (int k = 0; k < 3; k++) begin
      if (k == 0) v = tbl[4];
      else        v = tbl[0];
      drive(v);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_out_valid", out_valid, 1);
    chk("pre_rst_ovf", ovf, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_A_re", A_re, 0);
    tick();
    #2;
    rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (out_valid) stale++;
    end
    chk("no_stale_output", stale, 0);
    send_one_wait(tbl[1], lat);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_A_re", A_re, 600);
    chk("post_rst_B_re", B_re, 400);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_bfly_r2_pipe.md
Name: fft_bfly_r2_pipe

Overview:
Pipelined, parametrised radix-2 decimation-in-time butterfly for the streaming FFT datapath. It replaces the combinational add/subtract stage with a full butterfly: A = a + w·b and B = a − w·b.
- Adds twiddle multiplication, convergent-free round-half-up, optional per-stage divide-by-2 scaling, an inverse (conjugate-twiddle) mode, saturation with a sticky overflow flag, and a valid/ready handshake with stall.
- Sits between sample reorder memory and the next FFT stage.

Parameters:
DATA_W, 16, signed width of each real/imag sample component in and out
TW_W, 16, signed twiddle component width, format Q1.(TW_W-1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input pair valid
in_ready  out  1  block accepts input this cycle
a_re, a_im  in  DATA_W each  upper butterfly input
b_re, b_im  in  DATA_W each  lower butterfly input
w_re, w_im  in  TW_W each  twiddle
scale  in  1  sampled with input; 1 = divide outputs by 2
inverse  in  1  sampled with input; 1 = use conj(w)
out_valid  out  1  output pair valid
out_ready  in  1  downstream accepts output
A_re, A_im, B_re, B_im  out  DATA_W each  butterfly outputs
ovf  out  1  sticky saturation flag
clr_ovf  in  1  synchronous clear of ovf

Behaviour:
- Reset is asynchronous and active-low. On reset, all valid bits, out_valid, ovf and all data registers go to 0.
- Pipeline has 3 register stages; latency is 3 cycles from accepted input to out_valid when there is no stall.
- Pipeline control:
  - adv = !out_valid | out_ready.
  - in_ready = adv (combinational).
  - Transfer occurs on in_valid & in_ready.
  - When adv = 0, every stage holds its data and valid; no data is lost or duplicated.
  - Bubbles propagate as valid = 0 and may be overwritten.
- S1:
  - Register a (delayed copy), scale and inverse.
  - wi_eff = inverse ? −w_im : w_im. Negation saturates: −(−2^(TW_W−1)) becomes 2^(TW_W−1)−1.
  - Register the four signed products b_re·w_re, b_im·wi_eff, b_re·wi_eff, b_im·w_re, each DATA_W+TW_W bits.
- S2:
  - tr = p0 − p1 and ti = p2 + p3, each DATA_W+TW_W+1 bits.
  - Add 2^(TW_W−2), then arithmetic shift right by TW_W−1 (round half up).
  - Keep DATA_W+2 bits; no saturation at this point.
- S3:
  - Compute sA = a + t and sB = a − t at DATA_W+2 bits.
  - If scale: s = (s + 1) >>> 1.
  - Saturate each of the 4 components to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - Register the outputs.
- ovf:
  - Set in the cycle the S3 register loads a valid word in which any component saturated.
  - Held until clr_ovf.
  - If clr_ovf and a new saturation happen in the same cycle, set wins.
- Reset asserted mid-stream: all in-flight data is discarded. out_valid = 0 from assertion onward; first output appears 3 cycles after the first post-reset accepted input.
- Outputs are stable while out_valid & !out_ready.

Decomposition:
- Package fft_pkg holds:
  - default DATA_W/TW_W constants
  - the rounding constant function
  - the saturation function (sat(x, width))
  - the TW_ONE constant = 2^(TW_W−1)−1
- Natural sub-module: fft_cmul_pipe. It covers S1–S2: complex multiply with conjugate option, rounding and stall input. It is reused by later radix-4 work.

Test Plan:
- Forward multiply, DATA_W=TW_W=16: a=(1000,0), b=(200,0), w=(32767,0), scale=0, inverse=0 → 3 cycles later A=(1200,0), B=(800,0), ovf=0.
- Same stimulus with scale=1 → A=(600,0), B=(400,0).
- Twiddle −j: a=(1000,0), b=(200,0), w=(0,−32768).
  - inverse=0 → A=(1000,−200), B=(1000,200).
  - inverse=1 (saturated conj to 32767) → A=(1000,200), B=(1000,−200).
- Saturation: a=(32767,0), b=(32767,0), w=(32767,0), scale=0 → A_re=32767 (clipped from 65533), B_re=1, ovf=1 and stays 1 until a clr_ovf pulse. With scale=1 → A_re=32767 unclipped, ovf remains 0.
- Backpressure: stream 8 consecutive inputs and hold out_ready=0 for 5 cycles mid-burst → in_ready drops. All 8 results emerge in order, with no loss or duplicates, matching the reference model.
- Reset mid-operation: pulse rst_n low with 3 words in flight → out_valid=0 and ovf=0 immediately. No stale word appears after release; the next input emerges after exactly 3 cycles.
